// File: rtl/adder_checker.sv
// adder_checker: self-checking receiver for a pipelined adder's result stream.
// Forms (a+b) mod 2^WIDTH, delays it LATENCY cycles alongside a valid bit, and
// compares it with the adder output f. Keeps saturating check/error counters,
// a sticky error flag and a capture of the first mismatch.
// Optional feature: define ADDER_CHECKER_STOP_ON_ERR_EN to halt checking in a
// FAIL state after the first mismatch (left only by clr or p_reset).
module adder_checker #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 9
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] f,
  input  logic             clr,
  output logic             chk_valid,
  output logic             chk_ok,
  output logic             err_sticky,
  output logic [15:0]      chk_cnt,
  output logic [7:0]       err_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got
);

  typedef enum logic {
    CHECK = 1'b0
`ifdef ADDER_CHECKER_STOP_ON_ERR_EN
    , FAIL = 1'b1
`endif
  } state_e;

  // Expected-value pipeline: stage 1 in the low bits, stage LATENCY at the top.
  logic [LATENCY-1:0]       vld_q;
  logic [LATENCY*WIDTH-1:0] exp_q;
  logic [WIDTH-1:0]         sum_d;
  logic [WIDTH-1:0]         exp_tail;

  state_e           state_q;
  logic             chk_valid_q;
  logic             chk_ok_q;
  logic             err_sticky_q;
  logic [15:0]      chk_cnt_q;
  logic [7:0]       err_cnt_q;
  logic [WIDTH-1:0] first_exp_q;
  logic [WIDTH-1:0] first_got_q;

  logic             cmp_en;
  logic             match;
  logic [15:0]      chk_cnt_d;
  logic [7:0]       err_cnt_d;

  // Carry-out is dropped by truncation to WIDTH bits.
  assign sum_d    = a + b;
  assign exp_tail = exp_q[LATENCY*WIDTH-1 -: WIDTH];

  if (LATENCY > 1) begin : g_shift
    // Valid bits shift with reset so pre-reset samples are never checked.
    always_ff @(posedge m_clock or posedge p_reset) begin
      if (p_reset) vld_q <= '0;
      else         vld_q <= {vld_q[LATENCY-2:0], in_valid};
    end

    // Data stages are unreset, mirroring the adder's own registers.
    always_ff @(posedge m_clock) begin
      exp_q <= {exp_q[LATENCY*WIDTH-WIDTH-1:0], sum_d};
    end
  end else begin : g_single
    // Single-stage valid bit with reset.
    always_ff @(posedge m_clock or posedge p_reset) begin
      if (p_reset) vld_q <= '0;
      else         vld_q <= in_valid;
    end

    // Single unreset data stage.
    always_ff @(posedge m_clock) begin
      exp_q <= sum_d;
    end
  end

  assign cmp_en    = vld_q[LATENCY-1] && (state_q == CHECK);
  assign match     = (f == exp_tail);
  assign chk_cnt_d = (chk_cnt_q == '1) ? chk_cnt_q : chk_cnt_q + 16'd1;
  assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 8'd1;

  // Checker FSM with registered compare result, counters and first-error capture.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state_q      <= CHECK;
      chk_valid_q  <= 1'b0;
      chk_ok_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      chk_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_exp_q  <= '0;
      first_got_q  <= '0;
    end else if (clr) begin
      // clr wins over a comparison landing on the same edge.
      state_q      <= CHECK;
      chk_valid_q  <= 1'b0;
      chk_ok_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      chk_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_exp_q  <= '0;
      first_got_q  <= '0;
    end else begin
      chk_valid_q <= cmp_en;
      if (cmp_en) begin
        chk_ok_q  <= match;
        chk_cnt_q <= chk_cnt_d;
        if (!match) begin
          err_cnt_q    <= err_cnt_d;
          err_sticky_q <= 1'b1;
          if (!err_sticky_q) begin
            first_exp_q <= exp_tail;
            first_got_q <= f;
          end
`ifdef ADDER_CHECKER_STOP_ON_ERR_EN
          state_q <= FAIL;
`endif
        end
      end
    end
  end

  assign chk_valid  = chk_valid_q;
  assign chk_ok     = chk_ok_q;
  assign err_sticky = err_sticky_q;
  assign chk_cnt    = chk_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign first_exp  = first_exp_q;
  assign first_got  = first_got_q;

endmodule

// File: tb/tb_adder_checker.sv
// Testbench for adder_checker: random and directed stimulus, an adder model
// that schedules f values, and a queue-based reference scoreboard.
module tb_adder_checker;

  localparam int LAT = 9;

  logic        m_clock = 1'b0;
  logic        p_reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic [3:0]  f;
  logic        clr = 1'b0;
  logic        chk_valid;
  logic        chk_ok;
  logic        err_sticky;
  logic [15:0] chk_cnt;
  logic [7:0]  err_cnt;
  logic [3:0]  first_exp;
  logic [3:0]  first_got;

  adder_checker #(.WIDTH(4), .LATENCY(LAT)) dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .f          (f),
    .clr        (clr),
    .chk_valid  (chk_valid),
    .chk_ok     (chk_ok),
    .err_sticky (err_sticky),
    .chk_cnt    (chk_cnt),
    .err_cnt    (err_cnt),
    .first_exp  (first_exp),
    .first_got  (first_got)
  );

  initial forever #5 m_clock = ~m_clock;

  int n_checks = 0;
  int n_errors = 0;
  int n = 0;

  // Reference model: pending samples keyed by the edge they are due at.
  int         q_due[$];
  logic [3:0] q_exp[$];
  logic [3:0] fsched[int];
  bit         m_fail;
  bit         m_cv;
  bit         m_ok;
  bit         m_sticky;
  int         m_chk;
  int         m_err;
  logic [3:0] m_fe;
  logic [3:0] m_fg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_clear();
    m_fail = 0; m_cv = 0; m_ok = 0; m_sticky = 0;
    m_chk = 0; m_err = 0; m_fe = '0; m_fg = '0;
  endtask

  task automatic check_all();
    check("chk_valid", {31'd0, chk_valid}, {31'd0, m_cv});
    if (m_cv) check("chk_ok", {31'd0, chk_ok}, {31'd0, m_ok});
    check("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    check("chk_cnt", {16'd0, chk_cnt}, m_chk);
    check("err_cnt", {24'd0, err_cnt}, m_err);
    check("first_exp", {28'd0, first_exp}, {28'd0, m_fe});
    check("first_got", {28'd0, first_got}, {28'd0, m_fg});
  endtask

  // One clock: drive inputs, advance, update model, compare, schedule next f.
  task automatic step(input bit v, input logic [3:0] av, input logic [3:0] bv,
                      input bit c, input bit bad, input logic [3:0] badval);
    logic [3:0] f_seen;
    logic [3:0] s;
    logic [3:0] e;
    bit         hit;
    in_valid = v; a = av; b = bv; clr = c;
    f_seen = f;
    @(posedge m_clock);
    n++;
    #1;
    s = 4'((int'(av) + int'(bv)) % 16);
    if (v) begin
      q_due.push_back(n + LAT);
      q_exp.push_back(s);
      fsched[n + LAT] = bad ? badval : s;
    end
    m_cv = 0;
    e = '0;
    hit = (q_due.size() > 0) && (q_due[0] == n);
    if (hit) begin
      e = q_exp.pop_front();
      void'(q_due.pop_front());
    end
    if (c) begin
      model_clear();
    end else if (hit && !m_fail) begin
      m_cv = 1;
      m_ok = (f_seen === e);
      if (m_chk < 65535) m_chk++;
      if (!m_ok) begin
        if (!m_sticky) begin m_fe = e; m_fg = f_seen; end
        m_sticky = 1;
        if (m_err < 255) m_err++;
`ifdef ADDER_CHECKER_STOP_ON_ERR_EN
        m_fail = 1;
`endif
      end
    end
    check_all();
    if (fsched.exists(n + 1)) begin
      f = fsched[n + 1];
      fsched.delete(n + 1);
    end else begin
      f = 'x;
    end
    in_valid = 0; clr = 0;
  endtask

  task automatic bubbles(input int k);
    for (int i = 0; i < k; i++) step(0, 4'd0, 4'd0, 0, 0, 4'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, held over `hold` edges.
  task automatic mid_reset(input int hold);
    #2 p_reset = 1;
    #1;
    model_clear();
    q_due.delete(); q_exp.delete(); fsched.delete();
    check_all();
    repeat (hold) begin @(posedge m_clock); n++; end
    #1 p_reset = 0;
    in_valid = 0; clr = 0; f = 'x;
  endtask

  initial begin
    logic [3:0] x;
    logic [3:0] y;
    model_clear();
    f = 'x;
    mid_reset(2);

    // Latency: one sample 3+4 should pulse once, LAT edges later.
    step(1, 4'd3, 4'd4, 0, 0, 4'd0);
    bubbles(12);
    check("lat_cnt", {16'd0, chk_cnt}, 32'd1);
    check("lat_err", {24'd0, err_cnt}, 32'd0);

    // Wrap-around and streaming.
    step(0, 4'd0, 4'd0, 1, 0, 4'd0);
    step(1, 4'hF, 4'h3, 0, 0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      x = 4'($urandom_range(15)); y = 4'($urandom_range(15));
      step(1, x, y, 0, 0, 4'd0);
    end
    bubbles(12);
    check("stream_cnt", {16'd0, chk_cnt}, 32'd21);

    // Injected error on the 4th sample.
    step(0, 4'd0, 4'd0, 1, 0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) step(1, 4'd3, 4'd4, 0, 1, 4'h5);
      else begin
        x = 4'($urandom_range(15)); y = 4'($urandom_range(15));
        step(1, x, y, 0, 0, 4'd0);
      end
    end
    bubbles(12);
`ifdef ADDER_CHECKER_STOP_ON_ERR_EN
    check("inj_cnt", {16'd0, chk_cnt}, 32'd4);
`else
    check("inj_cnt", {16'd0, chk_cnt}, 32'd8);
    check("inj_err", {24'd0, err_cnt}, 32'd1);
    check("inj_fexp", {28'd0, first_exp}, 32'h7);
    check("inj_fgot", {28'd0, first_got}, 32'h5);
`endif
    check("inj_sticky", {31'd0, err_sticky}, 32'd1);

    // Bubbles and warm-up with f left X.
    mid_reset(1);
    bubbles(9);
    for (int i = 0; i < 20; i++) begin
      x = 4'($urandom_range(15)); y = 4'($urandom_range(15));
      step((i % 2) == 0, x, y, 0, 0, 4'd0);
    end
    bubbles(12);
    check("bub_cnt", {16'd0, chk_cnt}, 32'd10);
    check("bub_err", {24'd0, err_cnt}, 32'd0);

    // clr colliding with a mismatching comparison.
    step(0, 4'd0, 4'd0, 1, 0, 4'd0);
    step(1, 4'd2, 4'd2, 0, 1, 4'd0);
    bubbles(LAT - 1);
    step(0, 4'd0, 4'd0, 1, 0, 4'd0);
    check("clr_cnt0", {16'd0, chk_cnt}, 32'd0);
    check("clr_sticky0", {31'd0, err_sticky}, 32'd0);
    step(1, 4'd6, 4'd9, 0, 0, 4'd0);
    bubbles(12);
    check("clr_cnt1", {16'd0, chk_cnt}, 32'd1);
    check("clr_err1", {24'd0, err_cnt}, 32'd0);

    // Reset with five samples in flight.
    for (int i = 0; i < 5; i++) begin
      x = 4'($urandom_range(15)); y = 4'($urandom_range(15));
      step(1, x, y, 0, 0, 4'd0);
    end
    mid_reset(2);
    bubbles(15);
    check("rst_cnt", {16'd0, chk_cnt}, 32'd0);

    // Error counter saturation.
    step(0, 4'd0, 4'd0, 1, 0, 4'd0);
    for (int i = 0; i < 300; i++) begin
      x = 4'($urandom_range(15)); y = 4'($urandom_range(15));
      step(1, x, y, 0, 1, x + y + 4'd1);
    end
    bubbles(12);
`ifndef ADDER_CHECKER_STOP_ON_ERR_EN
    check("sat_err", {24'd0, err_cnt}, 32'hFF);
    check("sat_cnt", {16'd0, chk_cnt}, 32'd300);
`else
    check("sat_cnt", {16'd0, chk_cnt}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
